ccg_stim_response_harness: RTL



---
 rtl/ccg_stim_response_harness.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ccg_stim_response_harness.sv
// Stimulus/response harness for one flattened combinational benchmark.
// Drives LFSR vectors on x, holds each for SETTLE cycles, then folds the
// benchmark response f into a MISR signature and checks it against exp_sig.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; outputs hold the previous run's results
// DRIVE   | x is applied and held while the settle counter runs down
// CAPTURE | f is compacted into the MISR, next vector or finish chosen
// FINISH  | one-cycle done pulse, pass reflects the final signature
module ccg_stim_response_harness #(
  parameter int NUM_IN  = 21,
  parameter int NUM_OUT = 14,
  parameter int SIG_W   = 16,
  parameter int SETTLE  = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vectors,
  input  logic [NUM_IN-1:0]  seed,
  input  logic [SIG_W-1:0]   exp_sig,
  output logic [NUM_IN-1:0]  x,
  input  logic [NUM_OUT-1:0] f,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [SIG_W-1:0]   signature,
  output logic [CNT_W-1:0]   vec_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRIVE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_RELOAD = SET_W'(SETTLE - 1);
  localparam logic [SIG_W-1:0] MISR_POLY     = SIG_W'(16'h1021);

  logic [1:0]        state;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  num_q;
  logic [SIG_W-1:0]  exp_q;

  logic [SIG_W-1:0]  f_ext;
  logic [SIG_W-1:0]  sig_next;
  logic [CNT_W-1:0]  vec_next;
  logic [NUM_IN-1:0] x_next;
  logic [NUM_IN-1:0] seed_init;

  // Next-value datapath: MISR step, capture count, LFSR step, seed fix-up.
  always_comb begin
    f_ext = '0;
    f_ext[NUM_OUT-1:0] = f;
    sig_next = {signature[SIG_W-2:0], 1'b0}
               ^ (signature[SIG_W-1] ? MISR_POLY : '0)
               ^ f_ext;
    vec_next = vec_count + 1'b1;
    x_next = {x[NUM_IN-2:0], x[NUM_IN-1] ^ x[NUM_IN-3]};
    // An all-zero seed would lock the LFSR, so substitute 1.
    seed_init = (seed == '0) ? NUM_IN'(1) : seed;
  end

  assign busy = (state == S_DRIVE) || (state == S_CAPTURE);
  assign done = (state == S_FINISH);

  // Run sequencer: owns all state, stimulus and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      num_q      <= '0;
      exp_q      <= '0;
      x          <= '0;
      signature  <= '0;
      vec_count  <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_q      <= num_vectors;
            exp_q      <= exp_sig;
            x          <= seed_init;
            signature  <= '0;
            vec_count  <= '0;
            settle_cnt <= SETTLE_RELOAD;
            if (num_vectors == '0) begin
              // Empty run: the signature stays 0, so pass is known now.
              pass  <= (exp_sig == '0);
              state <= S_FINISH;
            end else begin
              pass  <= 1'b0;
              state <= S_DRIVE;
            end
          end
        end
        S_DRIVE: begin
          if (settle_cnt == '0) begin
            state <= S_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_CAPTURE: begin
          signature <= sig_next;
          vec_count <= vec_next;
          if (vec_next == num_q) begin
            // Compare against the final signature so pass is valid with done.
            pass  <= (sig_next == exp_q);
            state <= S_FINISH;
          end else begin
            x          <= x_next;
            settle_cnt <= SETTLE_RELOAD;
            state      <= S_DRIVE;
          end
        end
        S_FINISH: begin
          pass  <= (signature == exp_q);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
